l2_arbiter: RTL and testbench

- Two-port arbiter sharing the single L2 cache port between the L1 instruction cache and the L1 data cache.
- Sits between the split L1s and l2_cache and sequences one L2 transaction at a time.
- Captures the winning request into registers and holds it stable on the L2 side until l2_resp.
- Routes the response back to the winner only.
- Default priority goes to D; a streak counter bounds I starvation.

---
 rtl/l2_arbiter.sv | 124 ++++++++++++
 tb/tb_l2_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_arbiter.sv
// l2_arbiter: shares one L2 port between the L1 I-cache and D-cache.
// D wins by default; a streak counter bounds I starvation.
module l2_arbiter #(
  parameter int D_BURST_MAX = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_read,
  input  logic [15:0]  i_address,
  output logic [127:0] i_rdata,
  output logic         i_resp,
  input  logic         d_read,
  input  logic         d_write,
  input  logic [15:0]  d_address,
  input  logic [127:0] d_wdata,
  input  logic [15:0]  d_byte_enable,
  output logic [127:0] d_rdata,
  output logic         d_resp,
  output logic         l2_read,
  output logic         l2_write,
  output logic [15:0]  l2_address,
  output logic [127:0] l2_wdata,
  output logic [15:0]  l2_byte_enable,
  input  logic [127:0] l2_rdata,
  input  logic         l2_resp
);

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D,
    RELEASE
  } state_t;

  localparam logic [3:0] STREAK_MAX = 4'(D_BURST_MAX);

  state_t       state_q, state_d;
  logic [15:0]  addr_q, addr_d;
  logic [127:0] wdata_q, wdata_d;
  logic [15:0]  be_q, be_d;
  logic [3:0]   streak_q, streak_d;
  logic         was_write_q, was_write_d;

  logic i_req, d_req;
  logic grant_i, grant_d;

  assign i_req   = i_read;
  assign d_req   = d_read | d_write;
  assign grant_i = i_req & (~d_req | (streak_q == STREAK_MAX));
  assign grant_d = d_req & ~grant_i;

  // Next-state, capture and streak bookkeeping
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    streak_d    = streak_q;
    was_write_d = was_write_q;
    unique case (state_q)
      IDLE: begin
        unique case (1'b1)
          grant_i: begin
            addr_d   = i_address;
            streak_d = 4'd0;
            state_d  = SERVE_I;
          end
          grant_d: begin
            addr_d      = d_address;
            wdata_d     = d_wdata;
            be_d        = d_byte_enable;
            was_write_d = d_write;
            state_d     = SERVE_D;
            if (!i_req)
              streak_d = 4'd0;
            else if (streak_q != STREAK_MAX)
              streak_d = streak_q + 4'd1;
          end
          default: ;
        endcase
      end
      SERVE_I,
      SERVE_D: begin
        if (l2_resp)
          state_d = RELEASE;
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and capture registers, cleared asynchronously
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      streak_q    <= '0;
      was_write_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      streak_q    <= streak_d;
      was_write_q <= was_write_d;
    end
  end

  assign l2_read = (state_q == SERVE_I)
                 | ((state_q == SERVE_D) & ~was_write_q);
  assign l2_write = (state_q == SERVE_D) & was_write_q;

  assign l2_address     = addr_q;
  assign l2_wdata       = wdata_q;
  assign l2_byte_enable = be_q;

  assign i_rdata = l2_rdata;
  assign d_rdata = l2_rdata;
  assign i_resp  = (state_q == SERVE_I) & l2_resp;
  assign d_resp  = (state_q == SERVE_D) & l2_resp;

endmodule

// File: tb/tb_l2_arbiter.sv
// tb_l2_arbiter: scoreboard bench for l2_arbiter.
// Stimulus queues expected responses; a monitor checks each resp.
module tb_l2_arbiter;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         i_read = 1'b0;
  logic [15:0]  i_address = '0;
  logic [127:0] i_rdata;
  logic         i_resp;
  logic         d_read = 1'b0;
  logic         d_write = 1'b0;
  logic [15:0]  d_address = '0;
  logic [127:0] d_wdata = '0;
  logic [15:0]  d_byte_enable = '0;
  logic [127:0] d_rdata;
  logic         d_resp;
  logic         l2_read;
  logic         l2_write;
  logic [15:0]  l2_address;
  logic [127:0] l2_wdata;
  logic [15:0]  l2_byte_enable;
  logic [127:0] l2_rdata = '0;
  logic         l2_resp;
  logic         auto_resp = 1'b0;
  logic         spur_resp = 1'b0;

  assign l2_resp = auto_resp | spur_resp;

  always #5 clk = ~clk;

  l2_arbiter #(.D_BURST_MAX(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_read(i_read), .i_address(i_address),
    .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write),
    .d_address(d_address), .d_wdata(d_wdata),
    .d_byte_enable(d_byte_enable),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .l2_read(l2_read), .l2_write(l2_write),
    .l2_address(l2_address), .l2_wdata(l2_wdata),
    .l2_byte_enable(l2_byte_enable),
    .l2_rdata(l2_rdata), .l2_resp(l2_resp)
  );

  typedef struct {
    logic         wr;
    logic [15:0]  addr;
    logic [127:0] wdata;
    logic [15:0]  be;
  } exp_t;

  exp_t  exp_i[$];
  exp_t  exp_d[$];
  exp_t  e;
  string glog = "";
  int    ntest = 0;
  int    nerr = 0;
  int    cnt = 0;
  int    gap = 0;
  bit    gap_en = 0;
  bit    seen = 0;
  logic  prev_req = 1'b0;

  function automatic logic [127:0] l2_line(input logic [15:0] a);
    if (a == 16'h1230) return {16{8'hA5}};
    return {8{a ^ 16'hC3C3}};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    ntest++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // L2 model: answers each request after a fixed latency
  always @(posedge clk) begin
    auto_resp <= 1'b0;
    if (!reset_n) cnt <= 0;
    else if ((l2_read || l2_write) && !auto_resp) begin
      if (cnt == 3) begin
        auto_resp <= 1'b1;
        l2_rdata  <= l2_line(l2_address);
        cnt       <= 0;
      end else cnt <= cnt + 1;
    end else cnt <= 0;
  end

  // Scoreboard monitor: pops the served port's queue on each resp
  always @(negedge clk) if (reset_n) begin
    if (i_resp) begin
      glog = {glog, "I"};
      chk("i_only_resp", 128'(d_resp), 128'(0));
      if (exp_i.size() == 0) begin
        ntest++; nerr++;
        $display("FAIL i_resp_unexpected: got resp want none");
      end else begin
        e = exp_i.pop_front();
        chk("i_rdata", i_rdata, l2_line(e.addr));
        chk("i_l2_addr", 128'(l2_address), 128'(e.addr));
        chk("i_l2_rw", 128'({l2_read, l2_write}), 128'(2'b10));
      end
    end
    if (d_resp) begin
      glog = {glog, "D"};
      if (exp_d.size() == 0) begin
        ntest++; nerr++;
        $display("FAIL d_resp_unexpected: got resp want none");
      end else begin
        e = exp_d.pop_front();
        chk("d_rdata", d_rdata, l2_line(e.addr));
        chk("d_l2_addr", 128'(l2_address), 128'(e.addr));
        chk("d_l2_rw", 128'({l2_read, l2_write}),
            e.wr ? 128'(2'b01) : 128'(2'b10));
        if (e.wr) begin
          chk("d_l2_wdata", l2_wdata, e.wdata);
          chk("d_l2_be", 128'(l2_byte_enable), 128'(e.be));
        end
      end
    end
    if (d_read && d_write) begin
      ntest++; nerr++;
      $display("FAIL d_proto: got read and write both high want one");
    end
  end

  // Idle gap between back-to-back L2 transactions
  always @(negedge clk) begin
    if (gap_en) begin
      if (l2_read || l2_write) begin
        if (!prev_req && seen) chk("l2_gap", 128'(gap), 128'(2));
        seen = 1;
        gap  = 0;
      end else gap++;
    end
    prev_req = l2_read || l2_write;
  end

  task automatic wait_resp(input bit port_i, input string nm);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(port_i ? i_resp : d_resp) && k < 300);
    ntest++;
    if (!(port_i ? i_resp : d_resp)) begin
      nerr++;
      $display("FAIL %s_timeout: no resp after %0d cycles want resp",
               nm, k);
    end
  endtask

  task automatic i_stream(input int n, input logic [15:0] base);
    for (int k = 0; k < n; k++) begin
      exp_i.push_back('{1'b0, base + 16'(k * 16), 128'd0, 16'd0});
      i_read = 1'b1;
      i_address = base + 16'(k * 16);
      wait_resp(1'b1, "i_stream");
      @(posedge clk); #1;
    end
    i_read = 1'b0;
  endtask

  task automatic d_stream(input int n, input logic [15:0] base);
    for (int k = 0; k < n; k++) begin
      exp_d.push_back('{1'b0, base + 16'(k * 16), 128'd0, 16'd0});
      d_read = 1'b1;
      d_address = base + 16'(k * 16);
      wait_resp(1'b0, "d_stream");
      @(posedge clk); #1;
    end
    d_read = 1'b0;
  endtask

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    chk("rst_rw", 128'({l2_read, l2_write}), 128'(0));
    chk("rst_resp", 128'({i_resp, d_resp}), 128'(0));
    chk("rst_addr", 128'(l2_address), 128'(0));
    chk("rst_wdata", l2_wdata, 128'(0));
    chk("rst_be", 128'(l2_byte_enable), 128'(0));
    @(posedge clk); #1;
    reset_n = 1'b1;

    // single I read, request held into RELEASE
    @(posedge clk); #1;
    exp_i.push_back('{1'b0, 16'h1230, 128'd0, 16'd0});
    i_read = 1'b1;
    i_address = 16'h1230;
    @(negedge clk);
    chk("t1_lat_n", 128'(l2_read), 128'(0));
    @(negedge clk);
    chk("t1_lat_n1", 128'(l2_read), 128'(1));
    chk("t1_addr", 128'(l2_address), 128'(16'h1230));
    wait_resp(1'b1, "t1");
    @(posedge clk); #1;
    @(negedge clk);
    chk("t1_release", 128'({l2_read, l2_write}), 128'(0));
    @(posedge clk); #1;
    i_read = 1'b0;
    @(negedge clk);
    chk("t1_no_regrant", 128'({l2_read, l2_write}), 128'(0));
    chk("t1_q_empty", 128'(exp_i.size()), 128'(0));

    // D write with inputs changed after grant
    @(posedge clk); #1;
    exp_d.push_back('{1'b1, 16'h4000, {8{16'h1111}}, 16'h000F});
    d_write = 1'b1;
    d_address = 16'h4000;
    d_wdata = {8{16'h1111}};
    d_byte_enable = 16'h000F;
    @(negedge clk);
    @(negedge clk);
    chk("t2_lat", 128'({l2_read, l2_write}), 128'(2'b01));
    @(posedge clk); #1;
    d_wdata = {8{16'hEEEE}};
    d_byte_enable = 16'hFFFF;
    d_address = 16'h0BAD;
    wait_resp(1'b0, "t2");
    @(posedge clk); #1;
    d_write = 1'b0;
    repeat (4) @(negedge clk);
    chk("t2_q_empty", 128'(exp_d.size()), 128'(0));

    // contention: grant order with D_BURST_MAX = 4
    @(posedge clk); #1;
    glog = "";
    seen = 0;
    gap_en = 1;
    fork
      i_stream(2, 16'h2000);
      d_stream(8, 16'h5000);
    join
    repeat (2) @(negedge clk);
    gap_en = 0;
    ntest++;
    if (glog != "DDDDIDDDDI") begin
      nerr++;
      $display("FAIL t3_order: got %s want DDDDIDDDDI", glog);
    end
    chk("t3_qi_empty", 128'(exp_i.size()), 128'(0));
    chk("t3_qd_empty", 128'(exp_d.size()), 128'(0));

    // spurious l2_resp in IDLE
    @(posedge clk); #1;
    spur_resp = 1'b1;
    @(negedge clk);
    chk("t5_no_resp", 128'({i_resp, d_resp}), 128'(0));
    @(posedge clk); #1;
    spur_resp = 1'b0;
    @(negedge clk);
    chk("t5_idle", 128'({l2_read, l2_write}), 128'(0));

    // async reset during SERVE_D
    @(posedge clk); #1;
    d_write = 1'b1;
    d_address = 16'h6000;
    d_wdata = {8{16'h2222}};
    d_byte_enable = 16'hFFFF;
    @(negedge clk);
    @(negedge clk);
    chk("t6_serving", 128'(l2_write), 128'(1));
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_async_wr", 128'(l2_write), 128'(0));
    chk("t6_async_addr", 128'(l2_address), 128'(0));
    chk("t6_async_wdata", l2_wdata, 128'(0));
    d_write = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    exp_i.push_back('{1'b0, 16'h3330, 128'd0, 16'd0});
    i_read = 1'b1;
    i_address = 16'h3330;
    @(negedge clk);
    chk("t6_lat_n", 128'(l2_read), 128'(0));
    @(negedge clk);
    chk("t6_lat_n1", 128'(l2_read), 128'(1));
    chk("t6_addr", 128'(l2_address), 128'(16'h3330));
    wait_resp(1'b1, "t6");
    @(posedge clk); #1;
    i_read = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_qi_empty", 128'(exp_i.size()), 128'(0));
    chk("t6_qd_empty", 128'(exp_d.size()), 128'(0));

    $display("[TB] %0d tests run, %0d failed", ntest, nerr);
    $finish;
  end

endmodule
